if_id_queue: RTL and testbench

Parametrised fetch/decode front end for the RV32I pipeline. A DEPTH-entry instruction queue decouples instruction-memory returns from decode stalls, and a registered decode stage emits field selects, immediate and instruction class to execute. Generalises the single-slot IF/ID stage with configurable buffering, valid/ready handshake, pipeline flush and AUIPC decode.

---
 rtl/if_id_queue.sv | 217 +++++++++++++++++++++
 tb/tb_if_id_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   RV32I fetch/decode front end. Instruction-memory returns are buffered in a
//   DEPTH-entry FIFO so decode stalls do not back-pressure the memory port
//   combinationally. The head of the FIFO is decoded combinationally and
//   captured in a registered decode stage that feeds execute.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   fetch_valid/pc/inst instruction-memory return
//   fetch_ready         queue has a free entry (depends on occupancy only)
//   flush               discard queue contents and the decode register
//   stall               execute is not accepting; hold the decode register
//   dec_*               registered decode outputs
//   queue_count         current FIFO occupancy
//   exception           sticky fault: illegal instruction or misaligned pc
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4,
    parameter int          CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_inst,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             stall,
    output logic             dec_valid,
    output logic [31:0]      dec_pc,
    output logic [31:0]      dec_inst,
    output logic [31:0]      dec_imm,
    output logic [4:0]       dec_rs1,
    output logic [4:0]       dec_rs2,
    output logic [4:0]       dec_rd,
    output logic [2:0]       dec_func3,
    output logic             dec_subtype,
    output logic [9:0]       dec_class,
    output logic             dec_imm_sel,
    output logic [CNT_W-1:0] queue_count,
    output logic             exception
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // One-hot instruction classes, MSB first: auipc .. illegal
    localparam logic [9:0] CLS_AUIPC   = 10'b10_0000_0000;
    localparam logic [9:0] CLS_LUI     = 10'b01_0000_0000;
    localparam logic [9:0] CLS_JAL     = 10'b00_1000_0000;
    localparam logic [9:0] CLS_JALR    = 10'b00_0100_0000;
    localparam logic [9:0] CLS_BRANCH  = 10'b00_0010_0000;
    localparam logic [9:0] CLS_LOAD    = 10'b00_0001_0000;
    localparam logic [9:0] CLS_STORE   = 10'b00_0000_1000;
    localparam logic [9:0] CLS_ARITHI  = 10'b00_0000_0100;
    localparam logic [9:0] CLS_ARITHR  = 10'b00_0000_0010;
    localparam logic [9:0] CLS_ILLEGAL = 10'b00_0000_0001;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic push;
    logic pop;
    logic q_empty;

    // Ready is a pure function of occupancy: a word can only be accepted
    // into a free slot, never into one vacated by a same-cycle pop.
    assign fetch_ready = (count_reg < FULL_COUNT);
    assign q_empty     = (count_reg == '0);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign pop         = ~q_empty & (~dec_valid | ~stall) & ~flush;
    assign queue_count = count_reg;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= fetch_pc;
            inst_mem[wr_ptr_reg] <= fetch_inst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Combinational decode of the queue head
    // ------------------------------------------------------------------
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic [31:0] imm_i;
    logic [31:0] imm_shamt;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_next;
    logic [9:0]  class_next;
    logic        imm_sel_next;
    logic        subtype_next;
    logic        fault_next;

    assign head_pc   = pc_mem[rd_ptr_reg];
    assign head_inst = inst_mem[rd_ptr_reg];

    assign imm_i     = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_shamt = {27'd0, head_inst[24:20]};
    assign imm_s     = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b     = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                        head_inst[30:25], head_inst[11:8], 1'b0};
    assign imm_u     = {head_inst[31:12], 12'h000};
    assign imm_j     = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                        head_inst[20], head_inst[30:21], 1'b0};

    always_comb begin
        class_next = CLS_ILLEGAL;
        imm_next   = '0;
        if (head_inst[1:0] == 2'b11) begin
            case (head_inst[6:2])
                5'b00101: begin class_next = CLS_AUIPC;  imm_next = imm_u; end
                5'b01101: begin class_next = CLS_LUI;    imm_next = imm_u; end
                5'b11011: begin class_next = CLS_JAL;    imm_next = imm_j; end
                5'b11001: begin class_next = CLS_JALR;   imm_next = imm_i; end
                5'b11000: begin class_next = CLS_BRANCH; imm_next = imm_b; end
                5'b00000: begin class_next = CLS_LOAD;   imm_next = imm_i; end
                5'b01000: begin class_next = CLS_STORE;  imm_next = imm_s; end
                5'b00100: begin
                    class_next = CLS_ARITHI;
                    // Shifts (func3 001/101) carry a 5-bit shamt; inst[30]
                    // selects SRAI and must not leak into the immediate.
                    imm_next   = (head_inst[13:12] == 2'b01) ? imm_shamt : imm_i;
                end
                5'b01100: begin class_next = CLS_ARITHR; imm_next = '0; end
                default:  begin class_next = CLS_ILLEGAL; imm_next = '0; end
            endcase
        end
    end

    assign imm_sel_next = |(class_next & (CLS_JALR | CLS_LOAD | CLS_ARITHI));
    // ADDI has no subtype; inst[30] there is immediate bit 10, not SUB.
    assign subtype_next = head_inst[30]
                        & ~((class_next == CLS_ARITHI) && (head_inst[14:12] == 3'b000));
    assign fault_next   = class_next[0] | (head_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Decode register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid   <= 1'b0;
            dec_pc      <= RESET;
            dec_inst    <= NOP_INST;
            dec_imm     <= '0;
            dec_rs1     <= '0;
            dec_rs2     <= '0;
            dec_rd      <= '0;
            dec_func3   <= '0;
            dec_subtype <= 1'b0;
            dec_class   <= '0;
            dec_imm_sel <= 1'b0;
            exception   <= 1'b0;
        end else if (flush) begin
            // Payload is kept; only the valid flag is dropped.
            dec_valid <= 1'b0;
        end else if (pop) begin
            dec_valid   <= 1'b1;
            dec_pc      <= head_pc;
            dec_inst    <= head_inst;
            dec_imm     <= imm_next;
            dec_rs1     <= head_inst[19:15];
            dec_rs2     <= head_inst[24:20];
            dec_rd      <= head_inst[11:7];
            dec_func3   <= head_inst[14:12];
            dec_subtype <= subtype_next;
            dec_class   <= class_next;
            dec_imm_sel <= imm_sel_next;
            if (fault_next) begin
                exception <= 1'b1;
            end
        end else if (!stall) begin
            // Not stalled and nothing to pop: the queue is empty.
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = 3;

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_inst;
    logic             fetch_ready;
    logic             flush;
    logic             stall;
    logic             dec_valid;
    logic [31:0]      dec_pc;
    logic [31:0]      dec_inst;
    logic [31:0]      dec_imm;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [4:0]       dec_rd;
    logic [2:0]       dec_func3;
    logic             dec_subtype;
    logic [9:0]       dec_class;
    logic             dec_imm_sel;
    logic [CNT_W-1:0] queue_count;
    logic             exception;

    if_id_queue #(
        .RESET (RESET_PC),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .stall       (stall),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_inst    (dec_inst),
        .dec_imm     (dec_imm),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_func3   (dec_func3),
        .dec_subtype (dec_subtype),
        .dec_class   (dec_class),
        .dec_imm_sel (dec_imm_sel),
        .queue_count (queue_count),
        .exception   (exception)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // Scoreboard: entries accepted by the DUT, in the order they must decode
    entry_t      sb[$];
    logic [31:0] popped[$];
    entry_t      cur;
    logic        m_dv;
    logic        m_exc;
    int          checks = 0;
    int          errors = 0;
    logic        acc;

    function automatic logic [9:0] ref_class(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 10'h001;
        case (i[6:0])
            7'h17:   return 10'h200;
            7'h37:   return 10'h100;
            7'h6F:   return 10'h080;
            7'h67:   return 10'h040;
            7'h63:   return 10'h020;
            7'h03:   return 10'h010;
            7'h23:   return 10'h008;
            7'h13:   return 10'h004;
            7'h33:   return 10'h002;
            default: return 10'h001;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 32'h0;
        case (i[6:0])
            7'h17, 7'h37: return {i[31:12], 12'h000};
            7'h6F:        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'h67, 7'h03: return {{20{i[31]}}, i[31:20]};
            7'h13: begin
                if (i[13:12] == 2'b01) return {27'd0, i[24:20]};
                return {{20{i[31]}}, i[31:20]};
            end
            7'h63:        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h23:        return {{20{i[31]}}, i[31:25], i[11:7]};
            default:      return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_dv  = 1'b0;
        m_exc = 1'b0;
        cur   = '{pc: RESET_PC, inst: 32'h0000_0013};
    endtask

    // One clock of stimulus. Called at posedge+1; returns at the next posedge+1
    // after updating the scoreboard and checking the DUT outputs.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic fl, output logic accepted);
        logic       do_pop;
        logic       do_push;
        logic [9:0] cls;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_inst  = inst;
        stall       = st;
        flush       = fl;
        chk("fetch_ready", 32'(fetch_ready), 32'(sb.size() < DEPTH));
        do_pop  = (sb.size() > 0) && (!m_dv || !st) && !fl;
        do_push = fv && (sb.size() < DEPTH) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_dv = 1'b0;
        end else begin
            if (do_pop) begin
                cur  = sb.pop_front();
                m_dv = 1'b1;
                popped.push_back(cur.pc);
                cls = ref_class(cur.inst);
                if (cls[0] || cur.pc[1:0] != 2'b00) m_exc = 1'b1;
                $display("decode pc=%h inst=%h class=%h imm=%h", cur.pc, cur.inst, cls, ref_imm(cur.inst));
            end else if (!m_dv || !st) begin
                m_dv = 1'b0;
            end
            if (do_push) sb.push_back('{pc: pc, inst: inst});
        end
        accepted = do_push;
        chk("dec_valid", 32'(dec_valid), 32'(m_dv));
        chk("queue_count", 32'(queue_count), 32'(sb.size()));
        chk("exception", 32'(exception), 32'(m_exc));
        if (fl) begin
            chk("flush_hold_pc", dec_pc, cur.pc);
            chk("flush_hold_inst", dec_inst, cur.inst);
        end
        if (m_dv) begin
            cls = ref_class(cur.inst);
            chk("dec_pc", dec_pc, cur.pc);
            chk("dec_inst", dec_inst, cur.inst);
            chk("dec_imm", dec_imm, ref_imm(cur.inst));
            chk("dec_class", 32'(dec_class), 32'(cls));
            chk("dec_rs1", 32'(dec_rs1), 32'(cur.inst[19:15]));
            chk("dec_rs2", 32'(dec_rs2), 32'(cur.inst[24:20]));
            chk("dec_rd", 32'(dec_rd), 32'(cur.inst[11:7]));
            chk("dec_func3", 32'(dec_func3), 32'(cur.inst[14:12]));
            chk("dec_subtype", 32'(dec_subtype),
                32'(cur.inst[30] && !(cls == 10'h004 && cur.inst[14:12] == 3'b000)));
            chk("dec_imm_sel", 32'(dec_imm_sel), 32'((cls & 10'h054) != 10'h000));
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        got;

        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_inst  = '0;
        flush       = 1'b0;
        stall       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_dec_pc", dec_pc, RESET_PC);
        chk("rst_dec_inst", dec_inst, 32'h0000_0013);
        chk("rst_dec_imm", dec_imm, 32'd0);
        chk("rst_dec_rd", 32'(dec_rd), 32'd0);
        chk("rst_dec_class", 32'(dec_class), 32'd0);
        chk("rst_exception", 32'(exception), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);

        // Single addi: visible one edge after the push edge
        step(1'b1, 32'h0, 32'h0301_0413, 1'b0, 1'b0, acc);
        chk("t1_not_yet_valid", 32'(dec_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t1_valid", 32'(dec_valid), 32'd1);
        chk("t1_rd", 32'(dec_rd), 32'd8);
        chk("t1_rs1", 32'(dec_rs1), 32'd2);
        chk("t1_imm", dec_imm, 32'h30);
        chk("t1_class", 32'(dec_class), 32'h004);
        chk("t1_imm_sel", 32'(dec_imm_sel), 32'd1);
        chk("t1_count", 32'(queue_count), 32'd0);

        // Stall with five words offered: queue fills, fifth waits for stall release
        popped.delete();
        for (int k = 0; k < 4; k++) begin
            w = {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
            step(1'b1, 32'(k * 4), w, 1'b1, 1'b0, acc);
            chk("t2_accept", 32'(acc), 32'd1);
        end
        chk("t2_full_ready", 32'(fetch_ready), 32'd0);
        chk("t2_full_count", 32'(queue_count), 32'd4);
        w = {12'd4, 5'd0, 3'd0, 5'd1, 7'h13};
        step(1'b1, 32'h10, w, 1'b1, 1'b0, acc);
        chk("t2_fifth_blocked", 32'(acc), 32'd0);
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            step(1'b1, 32'h10, w, 1'b0, 1'b0, got);
        end
        chk("t2_fifth_accepted", 32'(got), 32'd1);
        for (int t = 0; t < 6; t++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t2_pop_total", 32'(popped.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_order", (k < popped.size()) ? popped[k] : 32'hDEAD_BEEF, 32'(k * 4));
        end

        // Directed immediates
        step(1'b1, 32'h20, 32'h0640_0793, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t3_addi_rd", 32'(dec_rd), 32'd15);
        chk("t3_addi_imm", dec_imm, 32'd100);
        step(1'b1, 32'h24, 32'h0000_1517, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t3_auipc_class", 32'(dec_class), 32'h200);
        chk("t3_auipc_imm", dec_imm, 32'h0000_1000);
        // beq x0,x0,-4
        step(1'b1, 32'h28, 32'hFE00_0EE3, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t3_branch_class", 32'(dec_class), 32'h020);
        chk("t3_branch_imm", dec_imm, 32'hFFFF_FFFC);
        // srai x5,x6,3: shamt zero-extended, subtype set
        step(1'b1, 32'h2C, 32'h4033_5293, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t3_srai_imm", dec_imm, 32'd3);
        chk("t3_srai_subtype", 32'(dec_subtype), 32'd1);

        // Flush with a concurrent push while count=3 and decode valid
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'(32'h30 + k * 4), 32'h0000_0013, 1'b1, 1'b0, acc);
        end
        chk("t4_pre_count", 32'(queue_count), 32'd3);
        chk("t4_pre_valid", 32'(dec_valid), 32'd1);
        step(1'b1, 32'h40, 32'h0010_0093, 1'b0, 1'b1, acc);
        chk("t4_count", 32'(queue_count), 32'd0);
        chk("t4_valid", 32'(dec_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t4_push_dropped", 32'(dec_valid), 32'd0);

        // Illegal instruction sets sticky exception; flush keeps it
        chk("t5_exc_clear", 32'(exception), 32'd0);
        step(1'b1, 32'h50, 32'hFFFF_FFFF, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t5_illegal_class", 32'(dec_class), 32'h001);
        chk("t5_illegal_imm", dec_imm, 32'd0);
        chk("t5_exception", 32'(exception), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        chk("t5_exc_after_flush", 32'(exception), 32'd1);

        // Asynchronous reset between edges with count=2
        step(1'b1, 32'h60, 32'h0000_0013, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h64, 32'h0000_0013, 1'b1, 1'b0, acc);
        step(1'b1, 32'h68, 32'h0000_0013, 1'b1, 1'b0, acc);
        chk("t6_pre_count", 32'(queue_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_count", 32'(queue_count), 32'd0);
        chk("t6_valid", 32'(dec_valid), 32'd0);
        chk("t6_dec_pc", dec_pc, RESET_PC);
        chk("t6_exception", 32'(exception), 32'd0);
        fetch_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Misaligned pc with a legal instruction
        step(1'b1, 32'h2, 32'h0000_0013, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("t7_valid", 32'(dec_valid), 32'd1);
        chk("t7_exception", 32'(exception), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        chk("t7_exc_after_flush", 32'(exception), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
